bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-client, single-owner arbiter between the fetch-stage instruction bus (ibus) and the memory-stage data bus (dbus), driving the core's single external memory bus. It grants one client at a time, forwards that client's request lines to the bus, routes response beats back to that client only, and holds ownership until the transaction completes. It sits in the core top level between the fetcher/datamemory stages and the system bus.

## Interface
- BUS_DATA_WIDTH, 64, width of req/resp data
- BUS_TAG_WIDTH, 13, width of req/resp tag
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high; clock clk
- ibus_req / dbus_req  in  BUS_DATA_WIDTH  client request word (address, or write data beat)
- ibus_reqcyc / dbus_reqcyc  in  1  client request valid
- ibus_reqtag / dbus_reqtag  in  BUS_TAG_WIDTH  client tag; bit 12 = 1 read, 0 write
- ibus_respack / dbus_respack  in  1  client accepts current response beat
- ibus_respcyc / dbus_respcyc  out  1  response beat valid to client
- ibus_resp / dbus_resp  out  BUS_DATA_WIDTH  response data to client
- ibus_resptag / dbus_resptag  out  BUS_TAG_WIDTH  response tag to client
- bus_req  out  BUS_DATA_WIDTH  request word to bus
- bus_reqcyc  out  1  request valid to bus
- bus_reqtag  out  BUS_TAG_WIDTH  request tag to bus
- bus_reqack  in  1  bus accepted request
- bus_respcyc  in  1  bus response beat valid
- bus_resp  in  BUS_DATA_WIDTH  bus response data
- bus_resptag  in  BUS_TAG_WIDTH  bus response tag
- bus_respack  out  1  ack of response beat to bus

## Operation
- States: IDLE, GRANT_I, GRANT_D. Registers: state, last_grant (I/D), acked flag, 3-bit beat counter, is_read flag.
- IDLE: only ibus_reqcyc -> GRANT_I; only dbus_reqcyc -> GRANT_D; both -> client not equal to last_grant (round-robin); none -> stay. On grant: latch is_read = owner reqtag[12], clear acked and counter, update last_grant.
- GRANT_x, request path: bus_req/bus_reqtag = owner's req/reqtag. Read: bus_reqcyc = owner reqcyc & ~acked; acked set on bus_reqack (so the address is issued exactly once even if the client keeps reqcyc high). Write: bus_reqcyc = owner reqcyc directly (owner streams address + data beats).
- GRANT_x, response path: owner's respcyc/resp/resptag = bus_respcyc/bus_resp/bus_resptag; bus_respack = owner respack. Non-owner: respcyc 0, resp 0, resptag 0.
- Completion: read -> after the 8th beat with bus_respcyc & bus_respack, go IDLE. Write -> when owner reqcyc is low, go IDLE.
- IDLE: bus_reqcyc 0, bus_req 0, bus_reqtag 0, bus_respack 0, both client respcyc 0. Bus beats arriving in IDLE are dropped unacked.
- Non-owner requests wait; no request is lost as long as the client holds reqcyc.

## Timing
- Reset: state IDLE, last_grant = I (first tie goes to dbus), acked 0, counter 0; every output 0 in the cycle after reset is sampled.
- Grant latency: reqcyc seen in IDLE at edge N -> bus_reqcyc driven from cycle N+1.
- Request and response forwarding is combinational within the granted state; there is no added latency per beat.
- Back-to-back: the cycle after completion is IDLE. The earliest new grant is one cycle later (one dead cycle between transactions).
- Beat counter increments only on bus_respcyc & bus_respack. A beat that is not acked is not counted.
- Reset mid-transaction: return to IDLE immediately. Remaining beats are dropped, and client outputs are forced to 0.

## Structure
- Shared package: tag field constants (BUS_TAG_READ bit index 12, READ=1, WRITE=0, MEMORY target code 4'b0001 in bits 11:8), BEATS_PER_LINE=8, the state enum.
- Single module with no sub-modules. Request mux and response demux are combinational; state, flags and counter are in one always_ff.

## Test plan
- Lone ibus read at 0x1000, tag[12]=1 -> bus_reqcyc=1 next cycle with bus_req=0x1000, dropped after reqack. 8 beats 0xA0..0xA7 appear on ibus_resp, dbus_respcyc stays 0, then return to IDLE.
- Simultaneous ibus and dbus reads right after reset -> dbus granted first, ibus granted on the second cycle after dbus's 8th beat.
- dbus read issued while ibus transaction is mid-burst -> dbus waits; no dbus beat is seen until ibus completes.
- dbus write of address 0x2000 plus 8 data beats, reqcyc held 9 cycles -> all 9 words pass to bus_req with tag unchanged; IDLE after reqcyc drops; no respcyc to either client.
- Response beat with bus_respack held low by the owner -> counter does not advance; the transaction completes only after 8 acked beats.
- Reset asserted after beat 3 -> all outputs 0 next cycle, state IDLE; the following read is granted normally.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the ibus/dbus memory bus arbiter: tag field layout,
// burst length and the arbiter state encoding.
package bus_arbiter_pkg;

  // Tag bit 12 selects read (1) or write (0); bits 11:8 carry the target code.
  localparam int         BUS_TAG_READ       = 12;
  localparam logic       BUS_TAG_READ_VAL   = 1'b1;
  localparam logic       BUS_TAG_WRITE_VAL  = 1'b0;
  localparam int         BUS_TAG_TARGET_LSB = 8;
  localparam logic [3:0] BUS_TAG_MEMORY     = 4'b0001;

  // A read returns one cache line as a fixed number of response beats.
  localparam int         BEATS_PER_LINE = 8;
  localparam logic [2:0] LAST_BEAT      = 3'(BEATS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } client_e;

endpackage

// File: rtl/bus_arbiter.sv
// Two-client single-owner arbiter between the instruction bus and the data bus.
// One client owns the memory bus at a time: its request lines are forwarded to
// the bus, bus response beats are routed back to it only, and ownership is held
// until a read has returned a full line or a write stream has ended.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_DATA_WIDTH-1:0] ibus_req,
  input  logic                      ibus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag,
  input  logic                      ibus_respack,
  output logic                      ibus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ibus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ibus_resptag,
  input  logic [BUS_DATA_WIDTH-1:0] dbus_req,
  input  logic                      dbus_reqcyc,
  input  logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag,
  input  logic                      dbus_respack,
  output logic                      dbus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] dbus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dbus_resptag,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic                      bus_reqcyc,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam logic [BUS_DATA_WIDTH-1:0] DATA_ZERO = {BUS_DATA_WIDTH{1'b0}};
  localparam logic [BUS_TAG_WIDTH-1:0]  TAG_ZERO  = {BUS_TAG_WIDTH{1'b0}};

  arb_state_e state_r;
  arb_state_e state_s;
  client_e    last_grant_r;
  logic       acked_r;
  logic       is_read_r;
  logic [2:0] beat_cnt_r;

  logic [BUS_DATA_WIDTH-1:0] own_req_s;
  logic                      own_reqcyc_s;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag_s;
  logic                      own_respack_s;
  logic                      bus_reqcyc_s;
  logic                      beat_ok_s;
  logic                      grant_start_s;
  logic                      new_is_read_s;

  // Select the owning client's request and response-ack lines; nothing in IDLE.
  always_comb begin
    own_req_s     = DATA_ZERO;
    own_reqcyc_s  = 1'b0;
    own_reqtag_s  = TAG_ZERO;
    own_respack_s = 1'b0;
    case (state_r)
      GRANT_I: begin
        own_req_s     = ibus_req;
        own_reqcyc_s  = ibus_reqcyc;
        own_reqtag_s  = ibus_reqtag;
        own_respack_s = ibus_respack;
      end
      GRANT_D: begin
        own_req_s     = dbus_req;
        own_reqcyc_s  = dbus_reqcyc;
        own_reqtag_s  = dbus_reqtag;
        own_respack_s = dbus_respack;
      end
      default: begin
        own_req_s     = DATA_ZERO;
        own_reqcyc_s  = 1'b0;
        own_reqtag_s  = TAG_ZERO;
        own_respack_s = 1'b0;
      end
    endcase
  end

  // Read addresses go out once (until accepted); write streams pass straight through.
  always_comb begin
    bus_reqcyc_s = 1'b0;
    if (is_read_r) begin
      bus_reqcyc_s = own_reqcyc_s & ~acked_r;
    end else begin
      bus_reqcyc_s = own_reqcyc_s;
    end
  end

  assign bus_req     = own_req_s;
  assign bus_reqtag  = own_reqtag_s;
  assign bus_reqcyc  = bus_reqcyc_s;
  assign bus_respack = own_respack_s;
  assign beat_ok_s   = bus_respcyc & own_respack_s;

  // Route response beats to the owner only; the other client sees all zeros.
  always_comb begin
    ibus_respcyc = 1'b0;
    ibus_resp    = DATA_ZERO;
    ibus_resptag = TAG_ZERO;
    dbus_respcyc = 1'b0;
    dbus_resp    = DATA_ZERO;
    dbus_resptag = TAG_ZERO;
    if (state_r == GRANT_I) begin
      ibus_respcyc = bus_respcyc;
      ibus_resp    = bus_resp;
      ibus_resptag = bus_resptag;
    end else if (state_r == GRANT_D) begin
      dbus_respcyc = bus_respcyc;
      dbus_resp    = bus_resp;
      dbus_resptag = bus_resptag;
    end else begin
      ibus_respcyc = 1'b0;
      dbus_respcyc = 1'b0;
    end
  end

  // Next owner: round-robin on a tie, release on line completion or end of write.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ibus_reqcyc && !dbus_reqcyc) begin
          state_s = GRANT_I;
        end else if (dbus_reqcyc && !ibus_reqcyc) begin
          state_s = GRANT_D;
        end else if (ibus_reqcyc && dbus_reqcyc) begin
          state_s = (last_grant_r == CLIENT_I) ? GRANT_D : GRANT_I;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (is_read_r) begin
          if (beat_ok_s && (beat_cnt_r == LAST_BEAT)) begin
            state_s = IDLE;
          end else begin
            state_s = state_r;
          end
        end else begin
          if (!own_reqcyc_s) begin
            state_s = IDLE;
          end else begin
            state_s = state_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Direction of the transaction being granted, taken from the winner's tag.
  always_comb begin
    grant_start_s = (state_r == IDLE) && (state_s != IDLE);
    new_is_read_s = 1'b0;
    if (state_s == GRANT_I) begin
      new_is_read_s = (ibus_reqtag[BUS_TAG_READ] == BUS_TAG_READ_VAL);
    end else begin
      new_is_read_s = (dbus_reqtag[BUS_TAG_READ] == BUS_TAG_READ_VAL);
    end
  end

  // State, ownership history, address-issued flag and response beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= CLIENT_I;
      acked_r      <= 1'b0;
      is_read_r    <= 1'b0;
      beat_cnt_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      if (grant_start_s) begin
        is_read_r    <= new_is_read_s;
        acked_r      <= 1'b0;
        beat_cnt_r   <= 3'd0;
        last_grant_r <= (state_s == GRANT_I) ? CLIENT_I : CLIENT_D;
      end else begin
        if (bus_reqcyc_s && bus_reqack) begin
          acked_r <= 1'b1;
        end
        if (beat_ok_s) begin
          beat_cnt_r <= beat_cnt_r + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected bus request words and per-client
// response beats are queued as stimulus is driven and consumed by a monitor
// on the falling edge; directed checks cover grant timing and idle behaviour.
module tb_bus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam logic [TW-1:0] RD_TAG = 13'h1100;
  localparam logic [TW-1:0] WR_TAG = 13'h0100;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] ibus_req, dbus_req, ibus_resp, dbus_resp, bus_req, bus_resp;
  logic          ibus_reqcyc, dbus_reqcyc, ibus_respack, dbus_respack;
  logic          ibus_respcyc, dbus_respcyc;
  logic [TW-1:0] ibus_reqtag, dbus_reqtag, ibus_resptag, dbus_resptag;
  logic [TW-1:0] bus_reqtag, bus_resptag;
  logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW+TW-1:0] req_q[$];
  logic [DW+TW-1:0] iresp_q[$];
  logic [DW+TW-1:0] dresp_q[$];

  bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .ibus_req(ibus_req), .ibus_reqcyc(ibus_reqcyc), .ibus_reqtag(ibus_reqtag),
    .ibus_respack(ibus_respack), .ibus_respcyc(ibus_respcyc),
    .ibus_resp(ibus_resp), .ibus_resptag(ibus_resptag),
    .dbus_req(dbus_req), .dbus_reqcyc(dbus_reqcyc), .dbus_reqtag(dbus_reqtag),
    .dbus_respack(dbus_respack), .dbus_respcyc(dbus_respcyc),
    .dbus_resp(dbus_resp), .dbus_resptag(dbus_resptag),
    .bus_req(bus_req), .bus_reqcyc(bus_reqcyc), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Every output folded into one vector; all-zero is the idle/reset signature.
  function automatic logic [7:0] outs();
    return {bus_reqcyc, bus_respack, ibus_respcyc, dbus_respcyc,
            |bus_req, |bus_reqtag, |{ibus_resp, ibus_resptag}, |{dbus_resp, dbus_resptag}};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_respcyc  = 1'b0;
    bus_resp     = 64'd0;
    bus_resptag  = 13'd0;
    ibus_respack = 1'b0;
    dbus_respack = 1'b0;
  endtask

  // One bus beat; the non-owner always acks so a misrouted beat is visible.
  task automatic drive_beat(input bit to_d, input logic [7:0] data, input bit ack);
    bus_respcyc  = 1'b1;
    bus_resp     = {8{data}};
    bus_resptag  = {5'b00000, data};
    ibus_respack = to_d ? 1'b1 : ack;
    dbus_respack = to_d ? ack : 1'b1;
  endtask

  task automatic burst(input bit to_d, input logic [7:0] base, input int nack_at,
                       input int raise_at, input int nbeats);
    logic [7:0] d;
    for (int k = 0; k < nbeats; k++) begin
      d = base + 8'(k);
      if (k == raise_at) begin
        dbus_req    = 64'h3000;
        dbus_reqtag = RD_TAG;
        dbus_reqcyc = 1'b1;
        req_q.push_back({64'h3000, RD_TAG});
      end
      if (k == nack_at) begin
        drive_beat(to_d, d, 1'b0);
        @(negedge clk);
        chk("respack_held_low", bus_respack, 1'b0);
        cyc();
      end
      drive_beat(to_d, d, 1'b1);
      if (to_d) dresp_q.push_back({{8{d}}, {5'b00000, d}});
      else      iresp_q.push_back({{8{d}}, {5'b00000, d}});
      @(negedge clk);
      chk("respack_fwd", bus_respack, 1'b1);
      cyc();
    end
    idle_bus();
  endtask

  // Issue a read from a client in IDLE, check grant latency and single address issue.
  task automatic read_grant(input bit to_d, input logic [DW-1:0] addr);
    if (to_d) begin
      dbus_req = addr; dbus_reqtag = RD_TAG; dbus_reqcyc = 1'b1;
    end else begin
      ibus_req = addr; ibus_reqtag = RD_TAG; ibus_reqcyc = 1'b1;
    end
    req_q.push_back({addr, RD_TAG});
    @(negedge clk);
    chk("grant_latency_idle", bus_reqcyc, 1'b0);
    cyc();
    @(negedge clk);
    chk("grant_reqcyc", bus_reqcyc, 1'b1);
    cyc();
    @(negedge clk);
    chk("addr_issued_once", bus_reqcyc, 1'b0);
    cyc();
    if (to_d) dbus_reqcyc = 1'b0;
    else      ibus_reqcyc = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", outs(), 8'd0);
    cyc();
  endtask

  task automatic idle_drop_check(input string tag);
    drive_beat(1'b0, 8'hEE, 1'b1);
    dbus_respack = 1'b1;
    @(negedge clk);
    chk(tag, {ibus_respcyc, dbus_respcyc, bus_respack}, 3'b000);
    cyc();
    idle_bus();
  endtask

  // Scoreboard monitor: consume expected bus words and client beats as they appear.
  always @(negedge clk) begin
    if (!reset && bus_reqcyc && bus_reqack) begin
      if (req_q.size() == 0) chk("bus_req_unexpected", bus_reqcyc, 1'b0);
      else chk("bus_req_word", {bus_req, bus_reqtag}, req_q.pop_front());
    end
    if (!reset && ibus_respcyc && ibus_respack) begin
      if (iresp_q.size() == 0) chk("ibus_resp_unexpected", ibus_respcyc, 1'b0);
      else chk("ibus_resp_beat", {ibus_resp, ibus_resptag}, iresp_q.pop_front());
    end
    if (!reset && dbus_respcyc && dbus_respack) begin
      if (dresp_q.size() == 0) chk("dbus_resp_unexpected", dbus_respcyc, 1'b0);
      else chk("dbus_resp_beat", {dbus_resp, dbus_resptag}, dresp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    ibus_req = 64'd0; ibus_reqcyc = 1'b0; ibus_reqtag = 13'd0;
    dbus_req = 64'd0; dbus_reqcyc = 1'b0; dbus_reqtag = 13'd0;
    bus_reqack = 1'b1;
    idle_bus();
    do_reset();

    // Lone ibus read: address once, 8 beats to ibus only, then idle.
    read_grant(1'b0, 64'h1000);
    burst(1'b0, 8'hA0, -1, -1, 8);
    idle_drop_check("idle_after_ibus_read");

    // Tie right after reset goes to dbus; ibus follows after one dead cycle.
    do_reset();
    ibus_req = 64'h1040; ibus_reqtag = RD_TAG; ibus_reqcyc = 1'b1;
    dbus_req = 64'h2040; dbus_reqtag = RD_TAG; dbus_reqcyc = 1'b1;
    req_q.push_back({64'h2040, RD_TAG});
    req_q.push_back({64'h1040, RD_TAG});
    @(negedge clk);
    chk("tie_latency_idle", bus_reqcyc, 1'b0);
    cyc();
    @(negedge clk);
    chk("tie_grant_dbus", {bus_reqcyc, bus_req}, {1'b1, 64'h2040});
    cyc();
    dbus_reqcyc = 1'b0;
    burst(1'b1, 8'hB0, -1, -1, 8);
    @(negedge clk);
    chk("dead_cycle_after_dbus", bus_reqcyc, 1'b0);
    cyc();
    @(negedge clk);
    chk("ibus_grant_second", {bus_reqcyc, bus_req}, {1'b1, 64'h1040});
    cyc();
    ibus_reqcyc = 1'b0;
    // ibus burst with one unacked beat; dbus read raised mid-burst must wait.
    burst(1'b0, 8'hC0, 3, 5, 8);
    @(negedge clk);
    chk("dbus_waits_dead_cycle", bus_reqcyc, 1'b0);
    cyc();
    @(negedge clk);
    chk("dbus_grant_after_ibus", {bus_reqcyc, bus_req}, {1'b1, 64'h3000});
    cyc();
    dbus_reqcyc = 1'b0;
    burst(1'b1, 8'hD0, -1, -1, 8);

    // dbus write: address plus 8 data words stream through with tag intact.
    dbus_req = 64'h2000; dbus_reqtag = WR_TAG; dbus_reqcyc = 1'b1;
    req_q.push_back({64'h2000, WR_TAG});
    @(negedge clk);
    chk("write_latency_idle", bus_reqcyc, 1'b0);
    cyc();
    @(negedge clk);
    chk("write_grant", bus_reqcyc, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      cyc();
      dbus_req = 64'h5500 + 64'(j);
      req_q.push_back({dbus_req, WR_TAG});
      @(negedge clk);
      chk("write_tag_fwd", {bus_reqcyc, bus_reqtag}, {1'b1, WR_TAG});
    end
    cyc();
    dbus_reqcyc = 1'b0;
    dbus_req = 64'd0;
    @(negedge clk);
    chk("write_reqcyc_drop", bus_reqcyc, 1'b0);
    cyc();
    idle_drop_check("idle_after_write");

    // Reset after beat 3 of an ibus read, then a normal read.
    read_grant(1'b0, 64'h1080);
    burst(1'b0, 8'h60, -1, -1, 3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive_beat(1'b0, 8'h63, 1'b1);
    @(negedge clk);
    chk("reset_mid_outputs", outs(), 8'd0);
    cyc();
    idle_bus();
    read_grant(1'b0, 64'h10C0);
    burst(1'b0, 8'hF0, -1, -1, 8);
    idle_drop_check("idle_after_reset_read");

    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("ibus_queue_drained", 32'(iresp_q.size()), 32'd0);
    chk("dbus_queue_drained", 32'(dresp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
